// File: rtl/mod_dmem_ctl.sv
// rtl/mod_dmem_ctl.sv - data-memory load/store sequencer for the 64-bit system bus; DMEM_CTL_STATS_EN adds activity counters
module mod_dmem_ctl #(
    parameter int               BEATS  = 8,
    parameter int               TAG_W  = 13,
    parameter logic [TAG_W-2:0] TAG_ID = 12'h0A5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [63:0]      mem_addr,
    input  logic [1:0]       mem_size,
    input  logic [63:0]      mem_wdata,
    output logic             mem_busy,
    output logic             load_done,
    output logic             store_done,
    output logic             mem_err,
    output logic [63:0]      load_buffer,
    output logic             bus_reqcyc,
    output logic [TAG_W-1:0] bus_reqtag,
    output logic [63:0]      bus_req,
    input  logic             bus_reqack,
    input  logic             bus_respcyc,
    input  logic [TAG_W-1:0] bus_resptag,
    input  logic [63:0]      bus_resp,
    output logic             bus_respack
`ifdef DMEM_CTL_STATS_EN
    ,
    output logic [31:0]      stat_loads,
    output logic [31:0]      stat_stores,
    output logic [31:0]      stat_errs,
    output logic [31:0]      stat_stall_cycles
`endif
);

    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t           state;
    logic             we_q;
    logic [63:0]      addr_q;
    logic [1:0]       size_q;
    logic [63:0]      wdata_q;
    logic [IDX_W-1:0] beat_cnt;
    logic [IDX_W-1:0] tgt_beat;
    logic [63:0]      cap_q;
    logic [63:0]      cap_word;
    logic             misalign;
    logic             hit;

    // Right-justify the addressed bytes of a beat and clear everything above the access size.
    function automatic logic [63:0] extract(input logic [63:0] beat, input logic [2:0] off,
                                            input logic [1:0] sz);
        logic [63:0] sh;
        sh = beat >> {off, 3'b000};
        case (sz)
            2'd0:    extract = {56'd0, sh[7:0]};
            2'd1:    extract = {48'd0, sh[15:0]};
            2'd2:    extract = {32'd0, sh[31:0]};
            default: extract = sh;
        endcase
    endfunction

    // An access that straddles the 8-byte beat boundary is rejected without touching the bus.
    assign misalign = ({1'b0, mem_addr[2:0]} + (4'd1 << mem_size)) > 4'd8;
    assign tgt_beat = (BEATS > 1) ? addr_q[3 +: IDX_W] : '0;
    assign hit      = (beat_cnt == tgt_beat);
    assign cap_word = extract(bus_resp, addr_q[2:0], size_q);

    // Responses carrying our read tag are always consumed, even stale ones outside RESP.
    assign bus_respack = bus_respcyc && (bus_resptag == {TAG_ID, 1'b0});

    // Bus request beats are decoded from the state register, so they hold steady until acked.
    always_comb begin
        bus_reqcyc = 1'b0;
        bus_req    = 64'd0;
        bus_reqtag = '0;
        mem_busy   = 1'b0;
        case (state)
            S_IDLE:  mem_busy = mem_req;
            S_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = {addr_q[63:3], 3'b000};
                bus_reqtag = {TAG_ID, we_q};
                mem_busy   = 1'b1;
            end
            S_WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_q << {addr_q[2:0], 3'b000};
                bus_reqtag = {TAG_ID, we_q};
                mem_busy   = 1'b1;
            end
            S_RESP:  mem_busy = 1'b1;
            default: mem_busy = 1'b0;
        endcase
    end

    // Access sequencer: latch request, run address/data/response beats, pulse completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= 64'd0;
            size_q      <= 2'd0;
            wdata_q     <= 64'd0;
            beat_cnt    <= '0;
            cap_q       <= 64'd0;
            load_buffer <= 64'd0;
            load_done   <= 1'b0;
            store_done  <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            store_done <= 1'b0;
            mem_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        we_q    <= mem_we;
                        addr_q  <= mem_addr;
                        size_q  <= mem_size;
                        wdata_q <= mem_wdata;
                        if (misalign) begin
                            state      <= S_DONE;
                            mem_err    <= 1'b1;
                            load_done  <= !mem_we;
                            store_done <= mem_we;
                        end else begin
                            state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus_reqack) begin
                        state <= we_q ? S_WDATA : S_RESP;
                    end
                end
                S_WDATA: begin
                    if (bus_reqack) begin
                        state      <= S_DONE;
                        store_done <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus_respack) begin
                        if (hit) begin
                            cap_q <= cap_word;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt    <= '0;
                            state       <= S_DONE;
                            load_done   <= 1'b1;
                            load_buffer <= hit ? cap_word : cap_q;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_CTL_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        sat_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating activity counters for performance monitoring.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_loads        <= 32'd0;
            stat_stores       <= 32'd0;
            stat_errs         <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            stat_loads        <= sat_inc(stat_loads, load_done);
            stat_stores       <= sat_inc(stat_stores, store_done);
            stat_errs         <= sat_inc(stat_errs, mem_err);
            stat_stall_cycles <= sat_inc(stat_stall_cycles, mem_busy);
        end
    end
`endif

endmodule

// File: tb/tb_mod_dmem_ctl.sv
// tb/tb_mod_dmem_ctl.sv - scoreboard bench for mod_dmem_ctl with a byte-addressed memory reference
module tb_mod_dmem_ctl;

    localparam int               BEATS  = 8;
    localparam int               TAG_W  = 13;
    localparam logic [TAG_W-2:0] TAG_ID = 12'h0A5;
    localparam logic [TAG_W-1:0] MATCH_TAG = {TAG_ID, 1'b0};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mem_req = 1'b0;
    logic             mem_we = 1'b0;
    logic [63:0]      mem_addr = 64'd0;
    logic [1:0]       mem_size = 2'd0;
    logic [63:0]      mem_wdata = 64'd0;
    logic             mem_busy, load_done, store_done, mem_err;
    logic [63:0]      load_buffer;
    logic             bus_reqcyc;
    logic [TAG_W-1:0] bus_reqtag;
    logic [63:0]      bus_req;
    logic             bus_reqack;
    logic             bus_respcyc;
    logic [TAG_W-1:0] bus_resptag;
    logic [63:0]      bus_resp;
    logic             bus_respack;
`ifdef DMEM_CTL_STATS_EN
    logic [31:0]      stat_loads, stat_stores, stat_errs, stat_stall_cycles;
`endif

    mod_dmem_ctl #(.BEATS(BEATS), .TAG_W(TAG_W), .TAG_ID(TAG_ID)) dut (
`ifdef DMEM_CTL_STATS_EN
        .stat_loads(stat_loads),
        .stat_stores(stat_stores),
        .stat_errs(stat_errs),
        .stat_stall_cycles(stat_stall_cycles),
`endif
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_busy(mem_busy), .load_done(load_done),
        .store_done(store_done), .mem_err(mem_err), .load_buffer(load_buffer),
        .bus_reqcyc(bus_reqcyc), .bus_reqtag(bus_reqtag), .bus_req(bus_req),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resptag(bus_resptag),
        .bus_resp(bus_resp), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic err; logic [63:0] val; int lat; int t0; } exp_t;
    typedef struct { logic we; logic [63:0] data; } qbeat_t;
    typedef struct { logic [TAG_W-1:0] tag; logic [63:0] data; } rbeat_t;

    exp_t        exp_q[$];
    qbeat_t      beat_q[$];
    rbeat_t      resp_q[$];
    logic [63:0] mem_words [logic [63:0]];

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          beats_acked = 0;
    int          fixed_dly = 0;
    bit          gap_en = 0;
    int          foreign_mode = 0;
    logic [63:0] last_load = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (reset) last_load = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input logic [63:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ (a >> 7) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Reference: an access reads or writes n consecutive bytes starting at addr.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] sz,
                         input logic [63:0] wd, input int lat, input bit push_exp);
        exp_t e;
        qbeat_t qb;
        int n, off;
        logic [63:0] b, byt;
        n = 1 << sz;
        off = int'(addr % 64'd8);
        e.we = we; e.err = (off + n > 8); e.lat = lat; e.t0 = cyc; e.val = 64'd0;
        if (!e.err) begin
            qb.we = we; qb.data = addr - (addr % 64'd8);
            beat_q.push_back(qb);
            if (we) begin
                qb.data = wd << (8 * off);
                beat_q.push_back(qb);
            end else begin
                for (int k = 0; k < n; k++) begin
                    b = addr + 64'(k);
                    byt = (word_at(b - (b % 64'd8)) >> (8 * (b % 64'd8))) & 64'hFF;
                    e.val = e.val | (byt << (8 * k));
                end
            end
        end
        if (push_exp) exp_q.push_back(e);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_size = sz; mem_wdata = wd;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (load_done || store_done) seen = 1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no done pulse, required one within 400 cycles", name);
        end
    endtask

    // Bus slave: acks request beats after a delay, checks them, returns line-ordered read data.
    initial begin : bus_model
        bit waiting;
        int dly;
        logic [63:0] h_req, base;
        logic [TAG_W-1:0] h_tag;
        rbeat_t rb;
        qbeat_t qb;
        waiting = 0; dly = 0;
        bus_reqack = 0; bus_respcyc = 0; bus_resptag = '0; bus_resp = '0;
        forever begin
            @(negedge clk);
            bus_respcyc = 1'b0;
            if (bus_reqack) begin bus_reqack = 1'b0; waiting = 0; end
            if (reset) waiting = 0;
            if (resp_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                rb = resp_q.pop_front();
                bus_respcyc = 1'b1; bus_resptag = rb.tag; bus_resp = rb.data;
            end
            if (bus_reqcyc) begin
                if (!waiting) begin
                    waiting = 1; h_req = bus_req; h_tag = bus_reqtag;
                    dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 2));
                end else begin
                    check("req_stable", bus_req, h_req);
                    check("tag_stable", 64'(bus_reqtag), 64'(h_tag));
                end
                if (dly == 0) begin
                    bus_reqack = 1'b1;
                    if (beat_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat: got req %h tag %h, required no bus traffic", bus_req, bus_reqtag);
                    end else begin
                        qb = beat_q.pop_front();
                        check("beat_data", bus_req, qb.data);
                        check("beat_tag", 64'(bus_reqtag), 64'({TAG_ID, qb.we}));
                    end
                    if (!bus_reqtag[0]) begin
                        base = bus_req & ~(64'(8 * BEATS) - 64'd1);
                        for (int i = 0; i < BEATS; i++) begin
                            if ((foreign_mode == 2 && i == 2) ||
                                (foreign_mode == 1 && $urandom_range(0, 3) == 0)) begin
                                rb.tag = ($urandom_range(0, 1) == 0) ? {TAG_ID ^ 12'h001, 1'b0} : {TAG_ID, 1'b1};
                                rb.data = {$urandom, $urandom};
                                resp_q.push_back(rb);
                            end
                            rb.tag = MATCH_TAG;
                            rb.data = word_at(base + 64'(8 * i));
                            resp_q.push_back(rb);
                        end
                    end
                end else begin
                    dly--;
                end
            end
            #1;
            if (bus_respcyc) begin
                check("respack", 64'(bus_respack), 64'(bus_resptag == MATCH_TAG));
                if (bus_respack) beats_acked++;
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (load_done || store_done) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got load_done %b store_done %b, required none", load_done, store_done);
                end else begin
                    e = exp_q.pop_front();
                    check("load_done", 64'(load_done), 64'(!e.we));
                    check("store_done", 64'(store_done), 64'(e.we));
                    check("mem_err", 64'(mem_err), 64'(e.err));
                    check("busy_in_done", 64'(mem_busy), 64'd0);
                    if (!e.we) begin
                        if (!e.err) last_load = e.val;
                        check("load_buffer", load_buffer, last_load);
                    end
                    if (e.lat >= 0) check("latency", 64'(cyc - e.t0), 64'(e.lat));
                end
            end else if (mem_err) begin
                tests++; fails++;
                $display("FAIL stray_err: got mem_err 1 outside done, required 0");
            end
        end
    end

    initial begin : stimulus
        int s;
        logic [63:0] a;
        logic [1:0] sz;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(mem_busy), 64'd0);
        check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("rst_reqtag", 64'(bus_reqtag), 64'd0);
        check("rst_done", 64'({load_done, store_done, mem_err}), 64'd0);
        check("rst_load_buffer", load_buffer, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        fixed_dly = 0; gap_en = 0; foreign_mode = 0;
        mem_words[64'h1010] = 64'h8877_6655_4433_2211;
        issue(1'b0, 64'h1013, 2'd1, 64'd0, BEATS + 2, 1);
        wait_done("tp_load");
        check("tp_load_value", load_buffer, 64'h5544);
        mem_req = 1'b0;
        @(negedge clk);

        fixed_dly = 3;
        issue(1'b1, 64'h2004, 2'd2, 64'hDEAD_BEEF, -1, 1);
        wait_done("tp_store");
        mem_req = 1'b0;
        @(negedge clk);

        fixed_dly = 0;
        issue(1'b0, 64'h3006, 2'd2, 64'd0, 1, 1);
        wait_done("tp_misalign");
        mem_req = 1'b0;
        @(negedge clk);

        foreign_mode = 2;
        issue(1'b0, 64'h4A28, 2'd3, 64'd0, -1, 1);
        wait_done("tp_foreign");
        mem_req = 1'b0;
        foreign_mode = 0;
        @(negedge clk);

        s = beats_acked;
        issue(1'b0, 64'h5040, 2'd3, 64'd0, -1, 0);
        for (int i = 0; i < 100 && beats_acked < s + 4; i++) begin @(negedge clk); #2; end
        @(posedge clk); #1;
        reset = 1'b1; mem_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 100 && resp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("stale_acked", 64'(beats_acked - s), 64'(BEATS));
        check("stale_load_buffer", load_buffer, 64'd0);
        mem_words[64'h0] = 64'h55;
        issue(1'b0, 64'h0, 2'd3, 64'd0, BEATS + 2, 1);
        wait_done("tp_reload");
        check("tp_reload_value", load_buffer, 64'h55);
        mem_req = 1'b0;
        @(negedge clk);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(1'b0, 64'h6010, 2'd3, 64'd0, BEATS + 2, 1);
        wait_done("b2b_first");
        issue(1'b0, 64'h7104, 2'd2, 64'd0, BEATS + 3, 1);
        wait_done("b2b_second");
        mem_req = 1'b0;
        @(negedge clk);
`ifdef DMEM_CTL_STATS_EN
        check("stat_loads", 64'(stat_loads), 64'd2);
`endif

        fixed_dly = -1; gap_en = 1; foreign_mode = 1;
        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            issue(1'($urandom_range(0, 1)), a, sz, {$urandom, $urandom}, -1, 1);
            wait_done("rand");
            mem_req = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("beats_empty", 64'(beat_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
